// File: rtl/ssm_pkg.sv
// ssm_pkg: shared word type, problem-size defaults and tx FSM encoding for the SSM wrapper slice
package ssm_pkg;
  localparam int DW = 16;
  typedef logic [DW-1:0] fp16_t;
  localparam int B_DEF = 1;
  localparam int H_DEF = 24;
  localparam int P_DEF = 64;
  localparam int N_DEF = 16;
  localparam int H_TILE = 4;
  localparam int P_TILE = 16;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;
endpackage

// File: rtl/y_stream_tx.sv
// y_stream_tx: captures the flat y result on done and streams it out as LANES-word valid/ready beats
module y_stream_tx #(
  parameter int B = ssm_pkg::B_DEF,
  parameter int H = ssm_pkg::H_DEF,
  parameter int P = ssm_pkg::P_DEF,
  parameter int DW = ssm_pkg::DW,
  parameter int LANES = ssm_pkg::P_TILE,
  localparam int NBEATS = B * H * P / LANES,
  localparam int BW = $clog2(NBEATS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap,
  input  logic [B*H*P*DW-1:0]   y_flat_in,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [LANES*DW-1:0]   m_data,
  output logic                  m_last,
  output logic [BW-1:0]         m_beat,
  output logic                  busy,
  output logic                  overflow
);
  import ssm_pkg::*;
  logic [0:0] state;
  logic [B*H*P*DW-1:0] frame;
  logic hs, at_last, accept;
  assign m_valid = state == S_STREAM;
  assign busy = m_valid;
  assign at_last = m_beat == BW'(NBEATS - 1);
  assign m_last = m_valid & at_last;
  assign hs = m_valid & m_ready;
  // a new frame is taken only when idle or exactly on the final handshake
  assign accept = cap & (~m_valid | (hs & at_last));
  assign m_data = frame[m_beat*LANES*DW +: LANES*DW];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      m_beat <= '0;
      overflow <= 1'b0;
    end else begin
      if (cap & ~accept) overflow <= 1'b1;
      if (accept) begin
        state <= S_STREAM;
        m_beat <= '0;
      end else if (hs) begin
        state <= at_last ? S_IDLE : S_STREAM;
        m_beat <= at_last ? '0 : m_beat + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) frame <= y_flat_in;
  end
endmodule

// File: tb/tb_y_stream_tx.sv
// tb_y_stream_tx: randomized and directed checks of y_stream_tx against a frame/position reference model
module tb_y_stream_tx;
  localparam int NW = 1536;
  localparam int LN = 16;
  localparam int NB = NW / LN;
  localparam int BWD = LN * 16;
  logic clk = 1'b0;
  logic rst, cap, m_ready, m_valid, m_last, busy, overflow;
  logic [NW*16-1:0] y_flat_in;
  logic [BWD-1:0] m_data;
  logic [$clog2(NB)-1:0] m_beat;
  int n_chk = 0, n_fail = 0;
  logic [15:0] cur[NW];
  int pos = 0;
  bit active = 0, ovf = 0;
  int hs_cnt = 0, last_cnt = 0;
  logic [15:0] w0;

  always #5 clk = ~clk;

  y_stream_tx dut (
    .clk(clk), .rst(rst), .cap(cap), .y_flat_in(y_flat_in), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .m_beat(m_beat), .busy(busy), .overflow(overflow)
  );

  task automatic check(string tag, logic [BWD-1:0] got, logic [BWD-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BWD-1:0] exp_data();
    logic [BWD-1:0] d;
    for (int j = 0; j < LN; j++) d[16*j +: 16] = cur[pos*LN + j];
    return d;
  endfunction

  task automatic load(int kind);
    for (int i = 0; i < NW; i++)
      y_flat_in[16*i +: 16] = kind == 0 ? 16'(i) : kind == 1 ? 16'hFFFF : 16'($urandom);
  endtask

  // one clock: drive cap/ready, advance the model by the stream rules, compare everything
  task automatic tick(bit c, bit r);
    bit hs, acc;
    cap = c;
    m_ready = r;
    if (m_valid && r) begin
      hs_cnt++;
      if (m_last) last_cnt++;
    end
    hs = active && r;
    acc = c && (!active || (hs && pos == NB - 1));
    if (c && !acc) ovf = 1;
    @(posedge clk);
    #1;
    cap = 0;
    if (acc) begin
      for (int i = 0; i < NW; i++) cur[i] = y_flat_in[16*i +: 16];
      pos = 0;
      active = 1;
    end else if (hs) begin
      if (pos == NB - 1) begin
        active = 0;
        pos = 0;
      end else pos++;
    end
    check("valid", m_valid, active);
    check("busy", busy, active);
    check("beat", m_beat, active ? pos : 0);
    check("last", m_last, active && pos == NB - 1);
    check("overflow", overflow, ovf);
    if (active) check("data", m_data, exp_data());
  endtask

  initial begin
    rst = 1;
    cap = 0;
    m_ready = 0;
    y_flat_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_beat", m_beat, 0);
    check("rst_last", m_last, 0);
    check("rst_overflow", overflow, 0);
    rst = 0;
    // ramp frame, always ready
    load(0);
    tick(1, 1);
    check("cap_latency", m_valid, 1);
    check("b0_lane0", m_data[15:0], 16'h0000);
    check("b0_lane15", m_data[255:240], 16'h000F);
    last_cnt = 0;
    for (int k = 0; k < NB - 1; k++) begin
      if (m_last) last_cnt++;
      tick(0, 1);
    end
    check("early_last", last_cnt, 0);
    check("b95_beat", m_beat, 95);
    check("b95_last", m_last, 1);
    check("b95_lane0", m_data[15:0], 16'h05F0);
    check("b95_lane15", m_data[255:240], 16'h05FF);
    tick(0, 1);
    check("end_valid", m_valid, 0);
    // backpressure at beat 5
    load(0);
    tick(1, 1);
    for (int g = 0; g < 20 && pos != 5; g++) tick(0, 1);
    for (int k = 0; k < 3; k++) begin
      tick(0, 0);
      check("bp_lane0", m_data[15:0], 16'h0050);
      check("bp_beat", m_beat, 5);
      check("bp_valid", m_valid, 1);
    end
    tick(0, 1);
    check("bp_next_lane0", m_data[15:0], 16'h0060);
    for (int g = 0; g < 200 && pos != NB - 1; g++) tick(0, 1);
    check("reach_b95", m_beat, NB - 1);
    // back-to-back capture on the final handshake
    load(2);
    w0 = y_flat_in[15:0];
    tick(1, 1);
    check("b2b_valid", m_valid, 1);
    check("b2b_beat", m_beat, 0);
    check("b2b_lane0", m_data[15:0], w0);
    check("b2b_overflow", overflow, 0);
    for (int g = 0; g < 200 && active; g++) tick(0, 1);
    check("b2b_drain", m_valid, 0);
    // dropped capture mid-frame
    load(0);
    tick(1, 1);
    for (int g = 0; g < 40 && pos != 20; g++) tick(0, 1);
    load(1);
    tick(1, 1);
    check("ovf_set", overflow, 1);
    check("ovf_b21_lane0", m_data[15:0], 16'h0150);
    for (int g = 0; g < 40 && pos != 40; g++) tick(0, 1);
    check("ovf_sticky", overflow, 1);
    check("reach_b40", m_beat, 40);
    // asynchronous reset in the middle of a cycle
    #2 rst = 1;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_last", m_last, 0);
    check("arst_beat", m_beat, 0);
    active = 0;
    pos = 0;
    ovf = 0;
    @(posedge clk);
    #1;
    rst = 0;
    check("arst_overflow", overflow, 0);
    // random ready over three frames
    for (int f = 0; f < 3; f++) begin
      load(2);
      hs_cnt = 0;
      last_cnt = 0;
      tick(1, 1'($urandom % 2));
      check("rnd_start_beat", m_beat, 0);
      for (int g = 0; g < 2000 && active; g++) tick(0, 1'($urandom % 2));
      check("rnd_beats", hs_cnt, NB);
      check("rnd_lasts", last_cnt, 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/y_stream_tx.md
Name: y_stream_tx

Overview:
- Output-side counterpart of the packing SSM wrapper.
- On the wrapper's done pulse it captures the full flat y result vector (B*H*P FP16 words) into a local buffer.
- It then streams the buffer out as LANES-word beats over a valid/ready interface, with a last flag on the final beat.
- Replaces bench-side whole-vector dumping with a handshaked result channel towards the host/DMA side.

Parameters:
- B, 1, batch size
- H, 24, number of heads
- P, 64, head dimension
- DW, 16, word width (FP16)
- LANES, 16, words per output beat (matches P_tile); B*H*P must be divisible by LANES
- NBEATS, B*H*P/LANES (96 at defaults), derived localparam, not overridable

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cap  in  1  single-cycle capture strobe; connect to the wrapper's done
- y_flat_in  in  B*H*P*DW  flat result; word i at [DW*i +: DW]; sampled only on accepted cap
- m_valid  out  1  beat valid
- m_ready  in  1  downstream ready
- m_data  out  LANES*DW  beat payload; lane j = word (beat*LANES + j), at [DW*j +: DW]
- m_last  out  1  high with the final beat (index NBEATS-1)
- m_beat  out  $clog2(NBEATS)  index of the current beat
- busy  out  1  frame held / streaming
- overflow  out  1  sticky: a cap was dropped

Behaviour:
- Reset (asynchronous, active-high):
  - m_valid=0, m_last=0, m_beat=0, busy=0, overflow=0, state=IDLE.
  - Buffer contents are don't-care.
  - Reset mid-stream aborts the frame; outputs go to reset values immediately, with no partial-beat completion.
- States: IDLE, STREAM.
- IDLE:
  - cap=1: latch y_flat_in into the buffer, beat=0, go to STREAM.
  - Latency: cap at edge t gives m_valid=1 with beat 0 after edge t (first valid cycle is t+1).
- STREAM:
  - m_valid=1, busy=1.
  - m_data = buffer[m_beat*LANES*DW +: LANES*DW].
  - m_last = (m_beat==NBEATS-1).
  - Handshake = m_valid & m_ready. On handshake with beat<NBEATS-1: beat+1.
  - On handshake with the last beat: if cap is also 1 that cycle, re-latch, beat=0 and stay in STREAM (back-to-back, no bubble); else go to IDLE with m_valid=0.
- Hold rule: while m_valid & !m_ready, m_data, m_beat and m_last are stable. m_valid never drops before the handshake.
- cap in STREAM other than on the final handshake cycle:
  - Ignored; the buffer is unchanged and the stream continues.
  - overflow is set to 1 and stays set until rst.
- The buffer is written only on accepted cap; y_flat_in may change freely otherwise.
- No arithmetic on data: words pass through bit-exact with no FP interpretation.
- m_beat counter width is $clog2(NBEATS). It never exceeds NBEATS-1 and has no wrap beyond the frame.
- m_ready is don't-care while m_valid=0.

Decomposition:
- Shared package (ssm_pkg):
  - DW=16 and the FP16 word type.
  - B/H/P/N defaults and H_tile/P_tile defaults, shared with the packing wrapper and its bench.
- A single module is natural. The beat select is an indexed part-select, and no sub-module is required.

Test Plan:
- Reset then cap with word i = i (16'h0000..16'h05FF), m_ready=1:
  - m_valid rises the cycle after cap.
  - Beat 0 lanes are 0x0000..0x000F.
  - 96 consecutive beats, m_last only on beat 95 (lanes 0x05F0..0x05FF).
  - m_valid=0 the cycle after.
- Backpressure: m_ready=0 for 3 cycles while m_beat=5 -> m_data lane0 holds 0x0050, m_beat=5, m_valid=1 throughout; beat 6 (0x0060) follows the first ready cycle.
- Overflow: second cap with different data (all 0xFFFF) while m_beat=20:
  - overflow=1 and stays 1.
  - Beats 20..95 still carry the original frame (beat 21 lane0 = 0x0150).
- Back-to-back: cap coincides with the beat-95 handshake -> next cycle is beat 0 of the new frame (lane0 = new word 0), m_valid never drops, overflow stays 0.
- Reset mid-stream at m_beat=40 -> m_valid, busy, m_last and m_beat go to 0 without waiting for a clock edge; a subsequent cap restarts cleanly from beat 0.
- Random m_ready (50%) over 3 frames -> scoreboard receives exactly 96 beats per frame in order, bit-exact, one m_last per frame.
